// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache array.
// Latency: n/a (types, constants and width helpers only).
// Backpressure: n/a.
//
// Contents: address-field width helpers, u_b_h_w bit positions, flush FSM state.
package cache_pkg;

    // u_b_h_w field positions: [2]=unsigned, [1]=word, [0]=half; both size bits 0 means byte
    localparam int UBHW_HALF_BIT = 0;
    localparam int UBHW_WORD_BIT = 1;
    localparam int UBHW_UNS_BIT  = 2;

    typedef enum logic {
        FL_IDLE = 1'b0,
        FL_WALK = 1'b1
    } flush_state_e;

    // addr = {tag, index, word, byte[1:0]}
    function automatic int idx_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int wrd_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int tag_bits(input int addr_bits, input int sets, input int line_words);
        return addr_bits - idx_bits(sets) - wrd_bits(line_words) - 2;
    endfunction

endpackage

// File: rtl/cache_lru_set.sv
// Per-set replacement helper: picks the victim way and computes the refreshed age vector.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle for the addressed set.
//
// Ports: valid/age of the set in, hit_way in; victim and age_next out.
// age 0 = most recently used, WAYS-1 = least recently used.
module cache_lru_set #(
    parameter int WAYS     = 4,
    parameter int WAY_BITS = $clog2(WAYS)
) (
    input  logic [WAYS-1:0]                valid,
    input  logic [WAYS-1:0][WAY_BITS-1:0]  age,
    input  logic [WAY_BITS-1:0]            hit_way,
    output logic [WAY_BITS-1:0]            victim,
    output logic [WAYS-1:0][WAY_BITS-1:0]  age_next
);

    always_comb begin
        victim = '0;
        // Oldest way first, then let any invalid way override; walking downward
        // leaves the lowest-index invalid way as the final choice.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (age[w] == WAY_BITS'(WAYS - 1)) victim = WAY_BITS'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w]) victim = WAY_BITS'(w);
        end
    end

    // Hit way becomes youngest; only ways younger than it age by one, so the
    // set stays a permutation of 0..WAYS-1.
    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            if (WAY_BITS'(w) == hit_way)
                age_next[w] = '0;
            else if (age[w] < age[hit_way])
                age_next[w] = age[w] + WAY_BITS'(1);
            else
                age_next[w] = age[w];
        end
    end

endmodule

// File: rtl/cache_assoc.sv
// N-way set-associative cache array with true-LRU replacement and a flush walker.
// Latency: 1 cycle; outputs reflect the command of the previous cycle, arrays write on the same edge.
// Backpressure: none; while busy (flush walk) every command and flush request is dropped.
//
// Ports: clk, rst (sync, active-low); addr/load/store/edit/invalid/u_b_h_w/din command;
// flush start; hit/dout/valid/dirty/tag/victim_way registered results; busy/flush_done walk status;
// hit_cnt/miss_cnt load/edit statistics, built only when CACHE_STATS_EN is defined (else tied 0).
module cache_assoc
    import cache_pkg::*;
#(
    parameter int ADDR_BITS  = 32,
    parameter int WAYS       = 4,
    parameter int SETS       = 32,
    parameter int LINE_WORDS = 4,
    parameter int STAT_BITS  = 32,
    // derived widths; leave at default
    parameter int TAG_BITS   = tag_bits(ADDR_BITS, SETS, LINE_WORDS),
    parameter int WAY_BITS   = $clog2(WAYS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic                 load,
    input  logic                 store,
    input  logic                 edit,
    input  logic                 invalid,
    input  logic [2:0]           u_b_h_w,
    input  logic [31:0]          din,
    input  logic                 flush,
    output logic                 hit,
    output logic [31:0]          dout,
    output logic                 valid,
    output logic                 dirty,
    output logic [TAG_BITS-1:0]  tag,
    output logic [WAY_BITS-1:0]  victim_way,
    output logic                 busy,
    output logic                 flush_done,
    output logic [STAT_BITS-1:0] hit_cnt,
    output logic [STAT_BITS-1:0] miss_cnt
);

    localparam int IDX_BITS = idx_bits(SETS);
    localparam int WRD_BITS = wrd_bits(LINE_WORDS);

    // ---------------- address split ----------------
    logic [TAG_BITS-1:0] a_tag;
    logic [IDX_BITS-1:0] a_idx;
    logic [WRD_BITS-1:0] a_wrd;
    logic [1:0]          a_off;
    assign a_off = addr[1:0];
    assign a_wrd = addr[2 +: WRD_BITS];
    assign a_idx = addr[2 + WRD_BITS +: IDX_BITS];
    assign a_tag = addr[ADDR_BITS-1 -: TAG_BITS];

    // ---------------- storage ----------------
    logic [31:0]         data_mem [SETS][WAYS][LINE_WORDS];
    logic [TAG_BITS-1:0] tag_mem  [SETS][WAYS];
    logic [SETS-1:0][WAYS-1:0]               valid_q, valid_d, dirty_q, dirty_d;
    logic [SETS-1:0][WAYS-1:0][WAY_BITS-1:0] age_q, age_d;

    // ---------------- flush FSM ----------------
    flush_state_e        state_q, state_d;
    logic [IDX_BITS-1:0] cnt_q, cnt_d;
    logic                flush_done_q, flush_done_d;
    logic                busy_w;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= FL_IDLE;
            cnt_q        <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flush_done_q <= flush_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            FL_IDLE: if (flush) begin
                state_d = FL_WALK;
                cnt_d   = '0;
            end
            FL_WALK: begin
                if (cnt_q == IDX_BITS'(SETS - 1)) begin
                    state_d = FL_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + IDX_BITS'(1);
                end
            end
            default: state_d = FL_IDLE;
        endcase
    end

    always_comb begin
        busy_w       = (state_q == FL_WALK);
        flush_done_d = busy_w && (cnt_q == IDX_BITS'(SETS - 1));
    end

    // ---------------- lookup ----------------
    logic [WAYS-1:0]                way_hit;
    logic [WAY_BITS-1:0]            hit_way, victim;
    logic                           hit_any;
    logic [WAYS-1:0][WAY_BITS-1:0]  age_ref;

    always_comb begin
        way_hit = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++)
            way_hit[w] = valid_q[a_idx][w] && (tag_mem[a_idx][w] == a_tag);
        for (int w = WAYS - 1; w >= 0; w--)
            if (way_hit[w]) hit_way = WAY_BITS'(w);
    end
    assign hit_any = |way_hit;

    cache_lru_set #(.WAYS(WAYS), .WAY_BITS(WAY_BITS)) u_lru (
        .valid    (valid_q[a_idx]),
        .age      (age_q[a_idx]),
        .hit_way  (hit_way),
        .victim   (victim),
        .age_next (age_ref)
    );

    // one command per cycle: invalid > store > edit > load
    logic cmd_inv, cmd_sto, cmd_edt, cmd_lod, cmd_idle;
    assign cmd_inv  = !busy_w && invalid;
    assign cmd_sto  = !busy_w && !invalid && store;
    assign cmd_edt  = !busy_w && !invalid && !store && edit;
    assign cmd_lod  = !busy_w && !invalid && !store && !edit && load;
    assign cmd_idle = !busy_w && !(invalid || store || edit || load);

    // ---------------- data path ----------------
    logic [31:0] rd_word, vic_word, ld_val, wr_word, mem_wdata;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;
    logic [WAY_BITS-1:0] mem_way;
    logic        mem_we;

    assign rd_word  = data_mem[a_idx][hit_way][a_wrd];
    assign vic_word = data_mem[a_idx][victim][a_wrd];
    assign half_sel = rd_word[{a_off[1], 4'b0000} +: 16];
    assign byte_sel = rd_word[{a_off, 3'b000} +: 8];

    always_comb begin
        if (u_b_h_w[UBHW_WORD_BIT])
            ld_val = rd_word;
        else if (u_b_h_w[UBHW_HALF_BIT])
            ld_val = u_b_h_w[UBHW_UNS_BIT] ? {16'h0000, half_sel} : {{16{half_sel[15]}}, half_sel};
        else
            ld_val = u_b_h_w[UBHW_UNS_BIT] ? {24'h000000, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
    end

    always_comb begin
        wr_word = rd_word;
        if (u_b_h_w[UBHW_WORD_BIT])
            wr_word = din;
        else if (u_b_h_w[UBHW_HALF_BIT])
            wr_word[{a_off[1], 4'b0000} +: 16] = din[15:0];
        else
            wr_word[{a_off, 3'b000} +: 8] = din[7:0];
    end

    // A refill word joins an already-present line so a multi-word refill stays in one way.
    assign mem_we    = cmd_sto || (cmd_edt && hit_any);
    assign mem_way   = (cmd_sto && !hit_any) ? victim : hit_way;
    assign mem_wdata = cmd_sto ? din : wr_word;

    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            data_mem[a_idx][mem_way][a_wrd] <= mem_wdata;
            tag_mem[a_idx][mem_way]         <= a_tag;
        end
    end

    // ---------------- valid / dirty / age ----------------
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        age_d   = age_q;
        if (busy_w) begin
            valid_d[cnt_q] = '0;
            dirty_d[cnt_q] = '0;
            for (int w = 0; w < WAYS; w++) age_d[cnt_q][w] = WAY_BITS'(w);
        end
        if (cmd_inv) begin
            valid_d[a_idx] = '0;
            dirty_d[a_idx] = '0;
            for (int w = 0; w < WAYS; w++) age_d[a_idx][w] = WAY_BITS'(w);
        end
        if (cmd_sto) begin
            valid_d[a_idx][mem_way] = 1'b1;
            dirty_d[a_idx][mem_way] = 1'b0;
        end
        if (cmd_edt && hit_any) begin
            dirty_d[a_idx][hit_way] = 1'b1;
            age_d[a_idx]            = age_ref;
        end
        if (cmd_lod && hit_any)
            age_d[a_idx] = age_ref;
    end

    // ---------------- registered outputs ----------------
    logic                hit_q, hit_d, out_valid_q, out_valid_d, out_dirty_q, out_dirty_d;
    logic [31:0]         dout_q, dout_d;
    logic [TAG_BITS-1:0] out_tag_q, out_tag_d;
    logic [WAY_BITS-1:0] out_way_q, out_way_d;

    always_comb begin
        hit_d       = 1'b0;
        dout_d      = dout_q;
        out_valid_d = out_valid_q;
        out_dirty_d = out_dirty_q;
        out_tag_d   = out_tag_q;
        out_way_d   = out_way_q;
        if (!busy_w) begin
            hit_d       = hit_any;
            out_valid_d = valid_q[a_idx][victim];
            out_dirty_d = dirty_q[a_idx][victim];
            out_tag_d   = tag_mem[a_idx][victim];
            out_way_d   = victim;
            if (cmd_lod && hit_any) dout_d = ld_val;
            else if (cmd_idle)      dout_d = vic_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q     <= '0;
            dirty_q     <= '0;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    age_q[s][w] <= WAY_BITS'(w);
            hit_q       <= 1'b0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
            out_dirty_q <= 1'b0;
            out_tag_q   <= '0;
            out_way_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            age_q       <= age_d;
            hit_q       <= hit_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
            out_dirty_q <= out_dirty_d;
            out_tag_q   <= out_tag_d;
            out_way_q   <= out_way_d;
        end
    end

    assign hit        = hit_q;
    assign dout       = dout_q;
    assign valid      = out_valid_q;
    assign dirty      = out_dirty_q;
    assign tag        = out_tag_q;
    assign victim_way = out_way_q;
    assign busy       = busy_w;
    assign flush_done = flush_done_q;

    // ---------------- statistics ----------------
`ifdef CACHE_STATS_EN
    logic [STAT_BITS-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    // saturating so a long run never wraps back to a small count
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (cmd_lod || cmd_edt) begin
            if (hit_any && !(&hit_cnt_q))   hit_cnt_d  = hit_cnt_q + STAT_BITS'(1);
            if (!hit_any && !(&miss_cnt_q)) miss_cnt_d = miss_cnt_q + STAT_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule
